// File: rtl/mem_stage_lsu_pkg.sv
// Shared constants and types for the memory-stage load/store unit.
package mem_pkg;

  localparam int NUM_LANES = 4;

  localparam logic [2:0] DM_W  = 3'b000;
  localparam logic [2:0] DM_HS = 3'b001;
  localparam logic [2:0] DM_HU = 3'b010;
  localparam logic [2:0] DM_BS = 3'b011;
  localparam logic [2:0] DM_BU = 3'b100;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC4 = 2'b10;

  typedef logic [0:0] lsu_state_t;
  localparam lsu_state_t S_IDLE = 1'b0;
  localparam lsu_state_t S_WAIT = 1'b1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] aluout;
    logic [31:0] memdata;
    logic [4:0]  rd;
    logic        regwrite;
    logic [1:0]  wdsel;
  } wb_bundle_t;

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane steering for stores, lane extraction/extension for loads, misalign detect.
module lsu_align
  import mem_pkg::*;
(
  input  logic [2:0]           dm_ctrl,
  input  logic [31:0]          addr,
  input  logic [31:0]          rd2,
  input  logic [31:0]          rdata,
  output logic [NUM_LANES-1:0] be_st,
  output logic [31:0]          wdata,
  output logic [31:0]          load_data,
  output logic                 misalign
);

  logic        is_b, is_h;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  // Anything that is not a byte or half encoding behaves as a word access.
  assign is_b = (dm_ctrl == DM_BS) || (dm_ctrl == DM_BU);
  assign is_h = (dm_ctrl == DM_HS) || (dm_ctrl == DM_HU);

  assign misalign = is_b ? 1'b0 : (is_h ? addr[0] : (addr[1:0] != 2'b00));

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_be
    localparam logic [1:0] LN = 2'(l);
    assign be_st[l] = is_b ? (addr[1:0] == LN) : (is_h ? (addr[1] == LN[1]) : 1'b1);
  end

  assign wdata = is_b ? {4{rd2[7:0]}} : (is_h ? {2{rd2[15:0]}} : rd2);

  always_comb begin
    ld_b = rdata[7:0];
    case (addr[1:0])
      2'd1:    ld_b = rdata[15:8];
      2'd2:    ld_b = rdata[23:16];
      2'd3:    ld_b = rdata[31:24];
      default: ld_b = rdata[7:0];
    endcase
  end

  assign ld_h = addr[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    load_data = rdata;
    case (dm_ctrl)
      DM_BS:   load_data = {{24{ld_b[7]}}, ld_b};
      DM_BU:   load_data = {24'h0, ld_b};
      DM_HS:   load_data = {{16{ld_h[15]}}, ld_h};
      DM_HU:   load_data = {16'h0, ld_h};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage: one data-bus transaction per load/store, upstream stall, MEM/WB register.
module mem_stage_lsu
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] MEM_PC,
  input  logic [4:0]  MEM_rd,
  input  logic [31:0] MEM_RD2,
  input  logic [31:0] MEM_aluout,
  input  logic [2:0]  MEM_dm_ctrl,
  input  logic        MEM_RegWrite,
  input  logic        MEM_mem_w,
  input  logic [1:0]  MEM_WDSel,
  input  logic        MEM_Flush,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  output logic [3:0]  dbus_be,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic        mem_stall,
  output logic [31:0] WB_PC,
  output logic [31:0] WB_aluout,
  output logic [31:0] WB_memdata,
  output logic [4:0]  WB_rd,
  output logic        WB_RegWrite,
  output logic [1:0]  WB_WDSel,
  output logic        misalign_exc,
  output logic [31:0] exc_addr,
  output logic        bus_err
);

  localparam logic [7:0] TO = 8'(TIMEOUT);

  lsu_state_t state;
  logic [7:0] cnt;
  logic       killed;

  logic [3:0]  be_st;
  logic [31:0] wdata, load_data;
  logic        misalign;
  logic        mem_op, in_wait, go, timeout_abort, killed_now, misalign_hit;
  wb_bundle_t  wb_d, wb_q;

  lsu_align u_align (
    .dm_ctrl   (MEM_dm_ctrl),
    .addr      (MEM_aluout),
    .rd2       (MEM_RD2),
    .rdata     (dbus_rdata),
    .be_st     (be_st),
    .wdata     (wdata),
    .load_data (load_data),
    .misalign  (misalign)
  );

  assign mem_op  = (MEM_mem_w || (MEM_WDSel == WD_MEM)) && !MEM_Flush;
  assign in_wait = (state == S_WAIT);
  // Once in WAIT the transaction is owned regardless of a late flush.
  assign go            = in_wait || (mem_op && !misalign);
  assign timeout_abort = in_wait && (cnt == TO) && !dbus_ack;
  assign killed_now    = killed || (in_wait && MEM_Flush);
  assign misalign_hit  = mem_op && misalign && !in_wait;

  assign dbus_req   = go;
  assign dbus_we    = go && MEM_mem_w;
  assign dbus_addr  = {MEM_aluout[31:2], 2'b00};
  assign dbus_wdata = wdata;
  assign dbus_be    = MEM_mem_w ? be_st : 4'hF;
  assign mem_stall  = go && !dbus_ack && !timeout_abort;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= 8'd0;
      killed <= 1'b0;
    end else if (!in_wait) begin
      killed <= 1'b0;
      if (go && !dbus_ack) begin
        state <= S_WAIT;
        cnt   <= 8'd1;
      end
    end else if (dbus_ack || timeout_abort) begin
      state  <= S_IDLE;
      cnt    <= 8'd0;
      killed <= 1'b0;
    end else begin
      cnt    <= cnt + 8'd1;
      killed <= killed_now;
    end
  end

  always_comb begin
    wb_d = '0;
    if (!mem_stall && !(MEM_Flush && !in_wait)) begin
      wb_d.pc       = MEM_PC;
      wb_d.aluout   = MEM_aluout;
      wb_d.memdata  = load_data;
      wb_d.rd       = MEM_rd;
      wb_d.wdsel    = MEM_WDSel;
      wb_d.regwrite = MEM_RegWrite && !misalign_hit && !timeout_abort && !killed_now;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_q         <= '0;
      misalign_exc <= 1'b0;
      exc_addr     <= 32'h0;
      bus_err      <= 1'b0;
    end else begin
      wb_q         <= wb_d;
      misalign_exc <= misalign_hit;
      bus_err      <= timeout_abort;
      if (misalign_hit) exc_addr <= MEM_aluout;
    end
  end

  assign WB_PC       = wb_q.pc;
  assign WB_aluout   = wb_q.aluout;
  assign WB_memdata  = wb_q.memdata;
  assign WB_rd       = wb_q.rd;
  assign WB_RegWrite = wb_q.regwrite;
  assign WB_WDSel    = wb_q.wdsel;

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Memory-stage load/store unit between the EX/MEM pipeline register and the register-file write-back path. Consumes the MEM_* bundle, runs one data-bus transaction per load/store over a req/ack handshake with byte enables, aligns and extends load data, and stalls upstream while the bus is busy. Registers the MEM/WB bundle for the write-back stage and flags misaligned accesses and bus timeouts.

## Interface
- TIMEOUT, 255: max WAIT cycles before abort; 1..255.
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- MEM_PC  in  32  PC of the MEM-stage instruction.
- MEM_rd  in  5  destination register.
- MEM_RD2  in  32  store data, unaligned, low bits significant.
- MEM_aluout  in  32  effective address / ALU result.
- MEM_dm_ctrl  in  3  access size/sign: DM_W=000, DM_HS=001, DM_HU=010, DM_BS=011, DM_BU=100.
- MEM_RegWrite  in  1  write-back enable.
- MEM_mem_w  in  1  store.
- MEM_WDSel  in  2  write-back source: WD_ALU=00, WD_MEM=01 (load), WD_PC4=10.
- MEM_Flush  in  1  kill current MEM instruction.
- dbus_req  out  1  transaction request.
- dbus_we  out  1  write.
- dbus_addr  out  32  word-aligned address ({aluout[31:2],2'b00}).
- dbus_wdata  out  32  lane-replicated store data.
- dbus_be  out  4  byte enables.
- dbus_ack  in  1  transaction complete; rdata valid for loads.
- dbus_rdata  in  32  read data.
- mem_stall  out  1  freeze PC/IF/ID/EX/EX-MEM.
- WB_PC, WB_aluout, WB_memdata  out  32 each  registered results.
- WB_rd  out  5; WB_RegWrite  out  1; WB_WDSel  out  2.
- misalign_exc  out  1  one-cycle registered pulse; exc_addr  out  32  faulting address.
- bus_err  out  1  one-cycle registered pulse on timeout.

## Operation
- mem_op = (MEM_mem_w | MEM_WDSel==WD_MEM) & ~MEM_Flush.
- Misaligned: W with addr[1:0]!=0; H with addr[0]!=0. No bus request; next edge misalign_exc=1, exc_addr=MEM_aluout, WB_RegWrite=0.
- States: IDLE, WAIT.
  - IDLE: aligned mem_op → dbus_req=1 combinationally. ack same cycle → complete, stay IDLE; else → WAIT, counter=1.
  - WAIT: dbus_req held, bus outputs stable (upstream frozen). ack → complete, → IDLE. counter==TIMEOUT without ack → drop req, bus_err pulse, WB_RegWrite=0, → IDLE.
- mem_stall = aligned mem_op & ~dbus_ack & ~timeout_abort (combinational, both states).
- Stores: B → be=1<<addr[1:0], wdata={4{RD2[7:0]}}; H → be=addr[1]?1100:0011, wdata={2{RD2[15:0]}}; W → be=1111, wdata=RD2. Loads: be=1111, we=0.
- Loads: select byte/half lane by addr[1:0]/addr[1], sign-extend (BS/HS) or zero-extend (BU/HU); invalid dm_ctrl on load treated as DM_W.
- MEM_Flush in WAIT: transaction completes (never abandoned), WB_RegWrite=0 for that instruction.
- WB register: each edge with mem_stall=0 loads MEM bundle (WB_memdata=extended load data); while mem_stall=1 loads bubble (WB_RegWrite=0, others 0). Flush loads bubble.

## Timing
- Reset: state=IDLE, counter=0, all WB_* outputs, misalign_exc, exc_addr, bus_err =0; dbus_* follow combinational rules (req=0 with reset-zeroed MEM inputs).
- Zero-wait access: ack in request cycle → no stall, WB valid next edge.
- N-cycle ack: mem_stall high N cycles, low in ack cycle; WB valid edge after ack.
- Timeout: req high TIMEOUT+1 cycles total, abort cycle stall=0.
- Reset mid-WAIT: immediate return to IDLE, req drops asynchronously with inputs.

## Structure
- Package mem_pkg: DM_* and WD_* constants, state typedef.
- Sub-module lsu_align (combinational): be/wdata generation, load extraction/extension, misalign detect.

## Test plan
- SW addr 0x100, RD2=0xDEADBEEF, ack same cycle → be=1111, wdata=0xDEADBEEF, mem_stall never 1.
- LB addr 0x103, rdata=0x80FF_FF12, ack after 3 cycles → mem_stall 3 cycles, WB_memdata=0xFFFFFF80, WB_RegWrite=1 one edge after ack.
- SH addr 0x202, RD2=0x1234ABCD → addr=0x200, be=1100, wdata=0xABCDABCD; LHU same addr rdata=0xABCD0000 → 0x0000ABCD.
- LW addr 0x101 → no dbus_req, misalign_exc=1 one cycle, exc_addr=0x101, WB_RegWrite=0.
- TIMEOUT=4, no ack → req 5 cycles, bus_err pulse, stall released, WB_RegWrite=0; MEM_Flush during a separate WAIT → ack accepted, WB_RegWrite=0.
